// File: rtl/modbus_link_ctrl_pkg.sv
// rtl/modbus_link_ctrl_pkg.sv - shared types and helpers for the Modbus RTU link sequencer
package modbus_link_ctrl_pkg;

  typedef enum logic [2:0] {
    LINK_IDLE_S,
    LINK_WAIT_T35_S,
    LINK_DE_LEAD_S,
    LINK_TX_S,
    LINK_DE_TAIL_S,
    LINK_RECOVER_S
  } link_fsm_t;

  localparam int CNT_W = 16;

  // statistics counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/modbus_link_ctrl_if.sv
// rtl/modbus_link_ctrl_if.sv - link sequencer signals between receive FSM, transmitter and transceiver
interface modbus_link_ctrl_if;
  import modbus_link_ctrl_pkg::*;

  logic             rxv;
  logic             resp_send;
  logic             ex_send;
  logic             tx_done;
  logic             tx_start;
  logic             tx_ex;
  logic             de;
  logic             fsm_rst;
  logic             busy;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] ex_cnt;
  logic [CNT_W-1:0] wd_cnt;

  modport master (
    output rxv, resp_send, ex_send, tx_done,
    input  tx_start, tx_ex, de, fsm_rst, busy, ok_cnt, ex_cnt, wd_cnt
  );

  modport slave (
    input  rxv, resp_send, ex_send, tx_done,
    output tx_start, tx_ex, de, fsm_rst, busy, ok_cnt, ex_cnt, wd_cnt
  );

endinterface

// File: rtl/modbus_bit_timer.sv
// rtl/modbus_bit_timer.sv - loadable tick down-counter shared by the lead, watchdog and tail phases
module modbus_bit_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  // reload wins; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // a load of N ticks lets the owner change state on the Nth edge after the load
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/modbus_link_ctrl.sv
// rtl/modbus_link_ctrl.sv - half-duplex RS-485 link sequencer for the Modbus RTU slave
import modbus_link_ctrl_pkg::*;

module modbus_link_ctrl #(
  parameter int PRESCALER    = 100,
  parameter int T35_BITS     = 39,
  parameter int DE_LEAD_BITS = 1,
  parameter int DE_TAIL_BITS = 1,
  parameter int WD_BITS      = 3000
) (
  input  logic                    clk,
  input  logic                    rst,
  modbus_link_ctrl_if.slave       lnk
);

  localparam int SIL_T  = T35_BITS * PRESCALER;
  localparam int SW     = $clog2(SIL_T + 1);
  localparam int LEAD_T = DE_LEAD_BITS * PRESCALER;
  localparam int TAIL_T = DE_TAIL_BITS * PRESCALER;
  localparam int WD_T   = WD_BITS * PRESCALER;
  localparam int TMAX0  = (LEAD_T > TAIL_T) ? LEAD_T : TAIL_T;
  localparam int TMAX   = (TMAX0 > WD_T) ? TMAX0 : WD_T;
  localparam int TW     = $clog2(TMAX + 1);
  localparam logic [SW-1:0] SIL_MAX = SW'(SIL_T);

  link_fsm_t        state_q, state_d;
  logic [SW-1:0]    sil_q, sil_d;
  logic             de_q, de_d;
  logic             tx_start_q, tx_start_d;
  logic             tx_ex_q, tx_ex_d;
  logic             fsm_rst_q, fsm_rst_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] ok_q, ok_d, ex_q, ex_d, wd_q, wd_d;
  logic             tmr_load, tmr_done, quiet;
  logic [TW-1:0]    tmr_val;

  assign quiet = (sil_q == SIL_MAX);

  modbus_bit_timer #(.W(TW)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // silence timer: any received byte (including our own echo) restarts it, it stops at saturation
  always_comb begin
    sil_d = sil_q;
    if (lnk.rxv) begin
      sil_d = '0;
    end else if (!quiet) begin
      sil_d = sil_q + SW'(1);
    end
  end

  // sequencer next state, phase timer loads and reply counters
  always_comb begin
    state_d  = state_q;
    tx_ex_d  = tx_ex_q;
    ok_d     = ok_q;
    ex_d     = ex_q;
    wd_d     = wd_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      LINK_IDLE_S: begin
        if (lnk.resp_send || lnk.ex_send) begin
          tx_ex_d = lnk.ex_send;
          state_d = LINK_WAIT_T35_S;
        end
      end
      LINK_WAIT_T35_S: begin
        if (quiet) begin
          state_d  = LINK_DE_LEAD_S;
          tmr_load = 1'b1;
          tmr_val  = TW'(LEAD_T);
        end
      end
      LINK_DE_LEAD_S: begin
        if (tmr_done) begin
          state_d  = LINK_TX_S;
          tmr_load = 1'b1;
          tmr_val  = TW'(WD_T);
        end
      end
      LINK_TX_S: begin
        // a completion in the same cycle as the watchdog expiry still counts as a reply
        if (lnk.tx_done) begin
          state_d  = LINK_DE_TAIL_S;
          tmr_load = 1'b1;
          tmr_val  = TW'(TAIL_T);
          if (tx_ex_q) begin
            ex_d = sat_inc(ex_q);
          end else begin
            ok_d = sat_inc(ok_q);
          end
        end else if (tmr_done) begin
          state_d = LINK_RECOVER_S;
          wd_d    = sat_inc(wd_q);
        end
      end
      LINK_DE_TAIL_S: begin
        if (tmr_done) begin
          state_d = LINK_RECOVER_S;
        end
      end
      LINK_RECOVER_S: state_d = LINK_IDLE_S;
      default:        state_d = LINK_IDLE_S;
    endcase
  end

  // outputs are registered, so derive them from the state being entered
  always_comb begin
    de_d       = (state_d == LINK_DE_LEAD_S) || (state_d == LINK_TX_S) || (state_d == LINK_DE_TAIL_S);
    tx_start_d = (state_q == LINK_DE_LEAD_S) && (state_d == LINK_TX_S);
    fsm_rst_d  = (state_d == LINK_RECOVER_S);
    busy_d     = (state_d != LINK_IDLE_S);
  end

  // state and output registers; reset holds the receive path in reset and releases the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LINK_IDLE_S;
      sil_q      <= SIL_MAX;
      de_q       <= 1'b0;
      tx_start_q <= 1'b0;
      tx_ex_q    <= 1'b0;
      fsm_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      ok_q       <= '0;
      ex_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      sil_q      <= sil_d;
      de_q       <= de_d;
      tx_start_q <= tx_start_d;
      tx_ex_q    <= tx_ex_d;
      fsm_rst_q  <= fsm_rst_d;
      busy_q     <= busy_d;
      ok_q       <= ok_d;
      ex_q       <= ex_d;
      wd_q       <= wd_d;
    end
  end

  assign lnk.de       = de_q;
  assign lnk.tx_start = tx_start_q;
  assign lnk.tx_ex    = tx_ex_q;
  assign lnk.fsm_rst  = fsm_rst_q;
  assign lnk.busy     = busy_q;
  assign lnk.ok_cnt   = ok_q;
  assign lnk.ex_cnt   = ex_q;
  assign lnk.wd_cnt   = wd_q;

endmodule
